// File: rtl/regfile_sb_pkg.sv
// regfile_sb shared constants and helpers.
// Build option: REGFILE_SB_INIT_EN loads GPR[i] = i at reset.
package regfile_sb_pkg;

  localparam int unsigned NUM_RD_DEF = 4;
  localparam int unsigned NUM_WR_DEF = 2;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;

  function automatic int unsigned slice_lo(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/read/writeback bundle between the pipeline and regfile_sb.
// Build option: REGFILE_SB_INIT_EN (affects reset contents only).
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic                     flush;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_WR-1:0]        iss_en;
  logic [NUM_WR*ADDR_W-1:0] iss_addr;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     hi_rd_en;
  logic                     lo_rd_en;
  logic [DATA_W-1:0]        hi_data;
  logic [DATA_W-1:0]        lo_data;
  logic                     hi_ready;
  logic                     lo_ready;
  logic                     hi_iss;
  logic                     lo_iss;
  logic                     hi_we;
  logic                     lo_we;
  logic [DATA_W-1:0]        hi_wdata;
  logic [DATA_W-1:0]        lo_wdata;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output flush,
    output rd_en, rd_addr,
    input  rd_data, rd_ready,
    output iss_en, iss_addr,
    output wr_en, wr_addr, wr_data,
    output hi_rd_en, lo_rd_en,
    input  hi_data, lo_data,
    input  hi_ready, lo_ready,
    output hi_iss, lo_iss,
    output hi_we, lo_we,
    output hi_wdata, lo_wdata,
    input  busy_cnt
  );

  modport slave (
    input  flush,
    input  rd_en, rd_addr,
    output rd_data, rd_ready,
    input  iss_en, iss_addr,
    input  wr_en, wr_addr, wr_data,
    input  hi_rd_en, lo_rd_en,
    output hi_data, lo_data,
    output hi_ready, lo_ready,
    input  hi_iss, lo_iss,
    input  hi_we, lo_we,
    input  hi_wdata, lo_wdata,
    output busy_cnt
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port: priority forward from N write ports over stored data.
// Build option: REGFILE_SB_INIT_EN has no effect here.
module regfile_bypass_mux
  import regfile_sb_pkg::*;
#(
  parameter int N       = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_EN = 1'b1
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   stored,
  input  logic                busy,
  input  logic [N-1:0]        wr_en,
  input  logic [N*ADDR_W-1:0] wr_addr,
  input  logic [N*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]   data,
  output logic                ready
);

  logic              is_zero;
  logic              hit;
  logic [DATA_W-1:0] fwd;

  assign is_zero = ZERO_EN &&
    (addr == ADDR_W'(REG_ZERO));

  // Ascending scan: the last match is the highest port.
  always_comb begin
    hit = 1'b0;
    fwd = stored;
    for (int j = 0; j < N; j++) begin
      if (wr_en[j] && !is_zero &&
          wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]
            == addr) begin
        hit = 1'b1;
        fwd = wr_data[slice_lo(j, DATA_W) +: DATA_W];
      end
    end
  end

  always_comb begin
    data  = '0;
    ready = 1'b0;
    if (en) begin
      data  = is_zero ? '0 : fwd;
      ready = !busy || hit || is_zero;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port GPR file with HI/LO, write bypass and pending-write scoreboard.
// Build option: define REGFILE_SB_INIT_EN to reset GPR[i] to i.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              hi_busy;
  logic              lo_busy;
  logic              hi_busy_nxt;
  logic              lo_busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef REGFILE_SB_INIT_EN
        regs[i] <= DATA_W'(i);
`else
        regs[i] <= '0;
`endif
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] &&
            bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]
              != ADDR_W'(REG_ZERO)) begin
          regs[bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]]
            <= bus.wr_data[slice_lo(j, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (bus.hi_we) hi_q <= bus.hi_wdata;
      if (bus.lo_we) lo_q <= bus.lo_wdata;
    end
  end

  // Clears go first so a same-cycle issue re-marks the entry.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j])
          busy_nxt[bus.wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]]
            = 1'b0;
      end
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.iss_en[j])
          busy_nxt[bus.iss_addr[slice_lo(j, ADDR_W) +: ADDR_W]]
            = 1'b1;
      end
    end
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_comb begin
    if (bus.flush)       hi_busy_nxt = 1'b0;
    else if (bus.hi_iss) hi_busy_nxt = 1'b1;
    else if (bus.hi_we)  hi_busy_nxt = 1'b0;
    else                 hi_busy_nxt = hi_busy;
    if (bus.flush)       lo_busy_nxt = 1'b0;
    else if (bus.lo_iss) lo_busy_nxt = 1'b1;
    else if (bus.lo_we)  lo_busy_nxt = 1'b0;
    else                 lo_busy_nxt = lo_busy;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= '0;
      hi_busy <= 1'b0;
      lo_busy <= 1'b0;
      cnt_q   <= '0;
    end else begin
      busy    <= busy_nxt;
      hi_busy <= hi_busy_nxt;
      lo_busy <= lo_busy_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = cnt_q;

  logic [NUM_RD*DATA_W-1:0] rd_dat;
  logic [NUM_RD-1:0]        rd_rdy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

    regfile_bypass_mux #(
      .N       (NUM_WR),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_EN (1'b1)
    ) u_mux (
      .en      (bus.rd_en[k]),
      .addr    (a),
      .stored  (regs[a]),
      .busy    (busy[a]),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_dat[slice_lo(k, DATA_W) +: DATA_W]),
      .ready   (rd_rdy[k])
    );
  end

  assign bus.rd_data  = rd_dat;
  assign bus.rd_ready = rd_rdy;

  regfile_bypass_mux #(
    .N       (1),
    .DATA_W  (DATA_W),
    .ADDR_W  (1),
    .ZERO_EN (1'b0)
  ) u_hi (
    .en      (bus.hi_rd_en),
    .addr    (1'b0),
    .stored  (hi_q),
    .busy    (hi_busy),
    .wr_en   (bus.hi_we),
    .wr_addr (1'b0),
    .wr_data (bus.hi_wdata),
    .data    (bus.hi_data),
    .ready   (bus.hi_ready)
  );

  regfile_bypass_mux #(
    .N       (1),
    .DATA_W  (DATA_W),
    .ADDR_W  (1),
    .ZERO_EN (1'b0)
  ) u_lo (
    .en      (bus.lo_rd_en),
    .addr    (1'b0),
    .stored  (lo_q),
    .busy    (lo_busy),
    .wr_en   (bus.lo_we),
    .wr_addr (1'b0),
    .wr_data (bus.lo_wdata),
    .data    (bus.lo_data),
    .ready   (bus.lo_ready)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb against an array-based reference model.
// Build option: REGFILE_SB_INIT_EN selects the reset pattern expected here too.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) bus ();

  regfile_sb #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit                       rst;
    bit                       flush;
    bit                       chk;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_WR-1:0]        iss_en;
    logic [NUM_WR*ADDR_W-1:0] iss_addr;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    bit                       hi_rd_en, lo_rd_en;
    bit                       hi_iss, lo_iss;
    bit                       hi_we, lo_we;
    logic [DATA_W-1:0]        hi_wdata, lo_wdata;
  } stim_t;

  typedef struct {
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_ready;
    logic [DATA_W-1:0]             hi_data, lo_data;
    logic                          hi_ready, lo_ready;
    logic [ADDR_W:0]               busy_cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] m_reg [DEPTH];
  bit                m_busy [DEPTH];
  logic [DATA_W-1:0] m_hi, m_lo;
  bit                m_hb, m_lb;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.chk = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef REGFILE_SB_INIT_EN
      m_reg[i] = DATA_W'(i);
`else
      m_reg[i] = '0;
`endif
      m_busy[i] = 1'b0;
    end
    m_hi = '0; m_lo = '0;
    m_hb = 1'b0; m_lb = 1'b0;
  endtask

  task automatic cycle(input stim_t s);
    exp_t e;
    int   a, n;
    bit   hit;
    @(posedge clk); #1;
    rst          = s.rst;
    bus.flush    = s.flush;
    bus.rd_en    = s.rd_en;
    bus.rd_addr  = s.rd_addr;
    bus.iss_en   = s.iss_en;
    bus.iss_addr = s.iss_addr;
    bus.wr_en    = s.wr_en;
    bus.wr_addr  = s.wr_addr;
    bus.wr_data  = s.wr_data;
    bus.hi_rd_en = s.hi_rd_en;
    bus.lo_rd_en = s.lo_rd_en;
    bus.hi_iss   = s.hi_iss;
    bus.lo_iss   = s.lo_iss;
    bus.hi_we    = s.hi_we;
    bus.lo_we    = s.lo_we;
    bus.hi_wdata = s.hi_wdata;
    bus.lo_wdata = s.lo_wdata;
    // Expected outputs for this cycle from current model state.
    for (int k = 0; k < NUM_RD; k++) begin
      a = int'(s.rd_addr[k*ADDR_W +: ADDR_W]);
      e.rd_data[k] = '0; e.rd_ready[k] = 1'b0;
      if (s.rd_en[k] && a == 0) begin
        e.rd_ready[k] = 1'b1;
      end else if (s.rd_en[k]) begin
        hit = 1'b0;
        e.rd_data[k] = m_reg[a];
        for (int j = NUM_WR-1; j >= 0; j--)
          if (!hit && s.wr_en[j] &&
              int'(s.wr_addr[j*ADDR_W +: ADDR_W]) == a) begin
            hit = 1'b1;
            e.rd_data[k] = s.wr_data[j*DATA_W +: DATA_W];
          end
        e.rd_ready[k] = !m_busy[a] || hit;
      end
    end
    e.hi_data  = s.hi_rd_en ? (s.hi_we ? s.hi_wdata : m_hi) : '0;
    e.lo_data  = s.lo_rd_en ? (s.lo_we ? s.lo_wdata : m_lo) : '0;
    e.hi_ready = s.hi_rd_en && (!m_hb || s.hi_we);
    e.lo_ready = s.lo_rd_en && (!m_lb || s.lo_we);
    n = 0;
    for (int i = 1; i < DEPTH; i++) n += int'(m_busy[i]);
    e.busy_cnt = (ADDR_W+1)'(n);
    if (s.chk) q.push_back(e);
    // Advance the model to the state after this edge.
    if (s.rst) begin
      model_reset();
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        a = int'(s.wr_addr[j*ADDR_W +: ADDR_W]);
        if (s.wr_en[j] && a != 0)
          m_reg[a] = s.wr_data[j*DATA_W +: DATA_W];
      end
      if (s.hi_we) m_hi = s.hi_wdata;
      if (s.lo_we) m_lo = s.lo_wdata;
      for (int i = 0; i < DEPTH; i++) begin
        bit is_iss, is_wr;
        is_iss = 1'b0; is_wr = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
          if (s.iss_en[j] &&
              int'(s.iss_addr[j*ADDR_W +: ADDR_W]) == i)
            is_iss = 1'b1;
          if (s.wr_en[j] &&
              int'(s.wr_addr[j*ADDR_W +: ADDR_W]) == i)
            is_wr = 1'b1;
        end
        if (i == 0 || s.flush) m_busy[i] = 1'b0;
        else if (is_iss)       m_busy[i] = 1'b1;
        else if (is_wr)        m_busy[i] = 1'b0;
      end
      if (s.flush)       m_hb = 1'b0;
      else if (s.hi_iss) m_hb = 1'b1;
      else if (s.hi_we)  m_hb = 1'b0;
      if (s.flush)       m_lb = 1'b0;
      else if (s.lo_iss) m_lb = 1'b1;
      else if (s.lo_we)  m_lb = 1'b0;
    end
  endtask

  // Monitor: compares every cycle for which an expectation was queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < NUM_RD; k++) begin
          chk($sformatf("rd_data[%0d]", k),
              bus.rd_data[k*DATA_W +: DATA_W], e.rd_data[k]);
          chk($sformatf("rd_ready[%0d]", k),
              32'(bus.rd_ready[k]), 32'(e.rd_ready[k]));
        end
        chk("hi_data", bus.hi_data, e.hi_data);
        chk("lo_data", bus.lo_data, e.lo_data);
        chk("hi_ready", 32'(bus.hi_ready), 32'(e.hi_ready));
        chk("lo_ready", 32'(bus.lo_ready), 32'(e.lo_ready));
        chk("busy_cnt", 32'(bus.busy_cnt), 32'(e.busy_cnt));
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    s = idle(); s.rst = 1'b1; s.chk = 1'b0;
    cycle(s);
    s.chk = 1'b1;
    cycle(s);
    // Reset contents.
    s = idle();
    s.rd_en = 4'b0011;
    s.rd_addr[4:0] = 5'd5;
    s.rd_addr[9:5] = 5'd0;
    s.hi_rd_en = 1'b1; s.lo_rd_en = 1'b1;
    cycle(s);
    // Two ports to r3: port 1 wins, bypass and stored.
    s = idle();
    s.wr_en = 2'b11;
    s.wr_addr = {5'd3, 5'd3};
    s.wr_data = {32'h5555, 32'hAAAA};
    s.rd_en[0] = 1'b1; s.rd_addr[4:0] = 5'd3;
    cycle(s);
    s = idle(); s.rd_en[0] = 1'b1; s.rd_addr[4:0] = 5'd3;
    cycle(s);
    // Issue r7, pending read, writeback bypass, release.
    s = idle(); s.iss_en = 2'b01; s.iss_addr[4:0] = 5'd7;
    cycle(s);
    s = idle(); s.rd_en[0] = 1'b1; s.rd_addr[4:0] = 5'd7;
    cycle(s);
    s.wr_en = 2'b01; s.wr_addr[4:0] = 5'd7;
    s.wr_data[31:0] = 32'h1234;
    cycle(s);
    s = idle(); s.rd_en[0] = 1'b1; s.rd_addr[4:0] = 5'd7;
    cycle(s);
    // Same-cycle issue and writeback of r9 stays busy.
    s = idle();
    s.iss_en = 2'b01; s.iss_addr[4:0] = 5'd9;
    s.wr_en = 2'b10; s.wr_addr[9:5] = 5'd9;
    s.wr_data[63:32] = 32'h99;
    cycle(s);
    s = idle(); s.rd_en[1] = 1'b1; s.rd_addr[9:5] = 5'd9;
    cycle(s);
    // Write to r0 is dropped, r0 reads 0 and ready.
    s = idle();
    s.wr_en = 2'b01; s.wr_addr[4:0] = 5'd0;
    s.wr_data[31:0] = 32'hFFFF;
    s.rd_en = 4'b0110;
    s.rd_addr[9:5] = 5'd9; s.rd_addr[14:10] = 5'd0;
    cycle(s);
    s = idle(); s.rd_en[2] = 1'b1; s.rd_addr[14:10] = 5'd0;
    cycle(s);
    // Flush beats same-cycle issue.
    s = idle();
    s.iss_en = 2'b11; s.iss_addr = {5'd4, 5'd2};
    s.hi_iss = 1'b1;
    cycle(s);
    s = idle(); s.flush = 1'b1;
    s.iss_en = 2'b01; s.iss_addr[4:0] = 5'd6;
    s.rd_en = 4'b0111;
    s.rd_addr[4:0] = 5'd2; s.rd_addr[9:5] = 5'd4;
    s.rd_addr[14:10] = 5'd6;
    s.hi_rd_en = 1'b1;
    cycle(s);
    s.flush = 1'b0; s.iss_en = '0;
    s.rd_addr[19:15] = 5'd3; s.rd_en = 4'b1111;
    cycle(s);
    // Reset during a pending write to r2.
    s = idle(); s.iss_en = 2'b01; s.iss_addr[4:0] = 5'd2;
    cycle(s);
    s = idle(); s.rst = 1'b1;
    s.wr_en = 2'b01; s.wr_addr[4:0] = 5'd2;
    s.wr_data[31:0] = 32'hDEAD;
    cycle(s);
    s = idle(); s.rd_en[0] = 1'b1; s.rd_addr[4:0] = 5'd2;
    cycle(s);
    // Randomized traffic on a narrow address range to force collisions.
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.flush = ($urandom_range(0, 29) == 0);
      s.rd_en = NUM_RD'($urandom);
      for (int k = 0; k < NUM_RD; k++)
        s.rd_addr[k*ADDR_W +: ADDR_W] =
          ADDR_W'($urandom_range(0, 9));
      for (int j = 0; j < NUM_WR; j++) begin
        s.iss_en[j] = ($urandom_range(0, 3) == 0);
        s.wr_en[j]  = ($urandom_range(0, 2) == 0);
        s.iss_addr[j*ADDR_W +: ADDR_W] =
          ADDR_W'($urandom_range(0, 9));
        s.wr_addr[j*ADDR_W +: ADDR_W] =
          ADDR_W'($urandom_range(0, 9));
        s.wr_data[j*DATA_W +: DATA_W] = $urandom;
      end
      s.hi_rd_en = $urandom_range(0, 1) == 1;
      s.lo_rd_en = $urandom_range(0, 1) == 1;
      s.hi_iss   = $urandom_range(0, 5) == 0;
      s.lo_iss   = $urandom_range(0, 5) == 0;
      s.hi_we    = $urandom_range(0, 3) == 0;
      s.lo_we    = $urandom_range(0, 3) == 0;
      s.hi_wdata = $urandom;
      s.lo_wdata = $urandom;
      cycle(s);
    end
    s = idle(); s.chk = 1'b0;
    cycle(s);
    @(posedge clk); #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 32x32 register file.
- Configurable read/write port counts, data width and depth; register 0 is hardwired to zero.
- Adds same-cycle write-to-read bypass, HI/LO registers with bypass, and a per-register pending-write scoreboard that gates read readiness.
- Sits between decode/issue (reads, scoreboard marks) and writeback (writes, scoreboard clears).

Parameters:
- NUM_RD, 4, number of GPR read ports
- NUM_WR, 2, number of GPR write ports; also the number of issue (mark) ports
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  clears all busy bits; data is preserved
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_ready  out  NUM_RD  operand valid and not pending
- iss_en  in  NUM_WR  mark destination as pending
- iss_addr  in  NUM_WR*ADDR_W  destinations to mark
- wr_en  in  NUM_WR  writeback enable
- wr_addr  in  NUM_WR*ADDR_W  writeback addresses
- wr_data  in  NUM_WR*DATA_W  writeback data
- hi_rd_en, lo_rd_en  in  1 each  HI/LO read enables
- hi_data, lo_data  out  DATA_W each  HI/LO read data
- hi_ready, lo_ready  out  1 each  HI/LO valid and not pending
- hi_iss, lo_iss  in  1 each  mark HI/LO pending
- hi_we, lo_we  in  1 each  HI/LO write enables
- hi_wdata, lo_wdata  in  DATA_W each  HI/LO write data
- busy_cnt  out  ADDR_W+1  registered count of pending GPRs

Behaviour:
- Reset (rst high at posedge):
  - all GPRs, HI and LO = 0
  - all busy bits = 0, busy_cnt = 0
  - reset overrides same-cycle writes, issues and flush
- Combinational read outputs, with rd_en = 0:
  - rd_data = 0, rd_ready = 0
  - hi_data/lo_data and hi_ready/lo_ready behave the same way when their enable is low
- Read, zero latency:
  - Bypass hit: any wr_en[j] with wr_addr[j] == rd_addr[k]. rd_data = wr_data of the highest matching j.
  - No hit: rd_data = stored value.
  - Address 0 always returns 0 and never hits bypass.
  - rd_ready[k] = rd_en[k] & (!busy[addr] | bypass hit | addr == 0).
- Write at posedge:
  - wr_en[j] and addr != 0: register takes wr_data[j].
  - Multiple ports to the same address: highest index wins.
  - Writes to address 0 are discarded.
- Scoreboard (next-state priority per entry, highest first):
  1. rst
  2. flush: clear all busy bits; same-cycle issues are ignored; same-cycle writes still commit data
  3. iss_en match: set busy. Issue and writeback to the same address in the same cycle leaves busy = 1, because the new producer wins.
  4. wr_en match: clear busy
  5. hold
- Entry 0 is never marked busy.
- Writeback to a non-busy entry: legal; data committed; busy stays 0.
- HI/LO:
  - Same bypass rules (hi_we forwards hi_wdata to hi_data).
  - Independent hi_busy/lo_busy with the same priority chain, including flush.
- busy_cnt:
  - registered population count of busy[1..depth-1], updated the cycle after the change
  - range 0..2**ADDR_W-1; cannot overflow

Optional Feature:
- Macro REGFILE_SB_INIT_EN.
- Defined: reset loads GPR[i] = i (zero-extended), i.e. the debug pattern; HI/LO = 0.
- Undefined: reset loads all GPRs = 0.
- Scoreboard behaviour is identical in both cases.

Decomposition:
- Package regfile_sb_pkg holds:
  - default parameter constants
  - REG_ZERO address constant
  - a function for packed-slice extraction
- One sub-module, regfile_bypass_mux: per-read-port priority forward select over NUM_WR write ports. Instantiate it NUM_RD times plus once each for HI and LO (with NUM_WR = 1).

Test Plan:
- rst; then read r5 -> rd_data 0 (5 with REGFILE_SB_INIT_EN); busy_cnt 0.
- wr_en[0] r3 = 0xAAAA and wr_en[1] r3 = 0x5555 in the same cycle; read r3 same cycle -> 0x5555 (bypass); next cycle stored value 0x5555.
- iss r7; next cycle read r7 -> rd_ready 0, busy_cnt 1; wr r7 = 0x1234 -> same-cycle rd_ready 1, data 0x1234; following cycle busy_cnt 0.
- iss r9 and wr r9 in the same cycle -> busy remains 1, busy_cnt 1; wr r9 = 0 address write to r0 = 0xFFFF -> r0 reads 0, ready 1.
- iss r2, r4, hi_iss; then flush with iss r6 the same cycle -> all busy 0, r6 not busy, busy_cnt 0, hi_ready 1; data unchanged.
- Pulse rst mid-pending with wr r2 in the same cycle -> r2 = 0, busy_cnt 0 next cycle.
